// File: rtl/servo_mode_sequencer_if.sv
// Servo mode sequencer signal bundle.
// Master drives requests; slave is the sequencer.
interface servo_mode_sequencer_if #(
  parameter int POS_W = 10
);
  logic             maint_req;
  logic             sort_busy;
  logic             sel_test;
  logic [POS_W-1:0] servo_test;
  logic             sort_hold;
  logic             maint_active;
  logic             sweep_done;

  modport master (
    output maint_req, sort_busy,
    input  sel_test, servo_test, sort_hold,
    input  maint_active, sweep_done
  );

  modport slave (
    input  maint_req, sort_busy,
    output sel_test, servo_test, sort_hold,
    output maint_active, sweep_done
  );
endinterface

// File: rtl/servo_mode_sequencer.sv
// Servo path mux controller: drains normal sorting,
// sweeps the servo in test mode, then hands it back.
module servo_mode_sequencer #(
  parameter int               POS_W     = 10,
  parameter logic [POS_W-1:0] POS_MIN   = 10'd0,
  parameter logic [POS_W-1:0] POS_MAX   = 10'd1000,
  parameter logic [POS_W-1:0] STEP      = 10'd100,
  parameter int               DWELL_W   = 24,
  parameter logic [DWELL_W-1:0] DWELL_CYC = 24'd5000000
) (
  input logic clk,
  input logic reset_n,
  servo_mode_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    PARK    = 3'd2,
    SWEEP   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [DWELL_W-1:0] D_ONE =
    {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] RELOAD =
    DWELL_CYC - D_ONE;
  localparam logic [POS_W:0] LO_LIM =
    {1'b0, POS_MIN} + {1'b0, STEP};

  state_t             state, state_n;
  logic               sel_q, sel_n;
  logic [POS_W-1:0]   pos_q, pos_n;
  logic               hold_q, hold_n;
  logic               act_q, act_n;
  logic               done_q, done_n;
  logic               down_q, down_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [POS_W:0]     sum_up;

  assign sum_up = {1'b0, pos_q} + {1'b0, STEP};

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      pos_q   <= POS_MIN;
      hold_q  <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      down_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      pos_q   <= pos_n;
      hold_q  <= hold_n;
      act_q   <= act_n;
      done_q  <= done_n;
      down_q  <= down_n;
      dwell_q <= dwell_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    pos_n   = pos_q;
    hold_n  = hold_q;
    act_n   = act_q;
    done_n  = 1'b0;
    down_n  = down_q;
    dwell_n = dwell_q;
    case (state)
      IDLE: begin
        sel_n  = 1'b0;
        pos_n  = POS_MIN;
        act_n  = 1'b0;
        hold_n = 1'b0;
        if (bus.maint_req) begin
          state_n = DRAIN;
          hold_n  = 1'b1;
        end
      end
      DRAIN: begin
        hold_n = 1'b1;
        sel_n  = 1'b0;
        if (!bus.maint_req) begin
          state_n = IDLE;
          hold_n  = 1'b0;
        end else if (!bus.sort_busy) begin
          state_n = PARK;
          sel_n   = 1'b1;
          pos_n   = POS_MIN;
          dwell_n = RELOAD;
          down_n  = 1'b0;
          act_n   = 1'b1;
        end
      end
      PARK, SWEEP: begin
        if (dwell_q != '0) begin
          dwell_n = dwell_q - D_ONE;
        end else if (!bus.maint_req) begin
          state_n = RELEASE;
          sel_n   = 1'b0;
          pos_n   = POS_MIN;
          act_n   = 1'b0;
        end else begin
          state_n = SWEEP;
          dwell_n = RELOAD;
          if (!down_q) begin
            if (sum_up >= {1'b0, POS_MAX}) begin
              pos_n  = POS_MAX;
              down_n = 1'b1;
            end else begin
              pos_n = sum_up[POS_W-1:0];
            end
          end else begin
            if ({1'b0, pos_q} <= LO_LIM) begin
              pos_n  = POS_MIN;
              down_n = 1'b0;
              done_n = 1'b1;
            end else begin
              pos_n = pos_q - STEP;
            end
          end
        end
      end
      RELEASE: begin
        state_n = IDLE;
        hold_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        sel_n   = 1'b0;
        pos_n   = POS_MIN;
        hold_n  = 1'b0;
        act_n   = 1'b0;
        down_n  = 1'b0;
        dwell_n = '0;
      end
    endcase
  end

  assign bus.sel_test     = sel_q;
  assign bus.servo_test   = pos_q;
  assign bus.sort_hold    = hold_q;
  assign bus.maint_active = act_q;
  assign bus.sweep_done   = done_q;

endmodule

// File: tb/tb_servo_mode_sequencer.sv
// Directed bench for servo_mode_sequencer.
// Small dwell so full sweeps fit in a short run.
module tb_servo_mode_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  servo_mode_sequencer_if #(.POS_W(10)) bus ();

  servo_mode_sequencer #(
    .POS_W(10),
    .POS_MIN(10'd0),
    .POS_MAX(10'd1000),
    .STEP(10'd300),
    .DWELL_W(24),
    .DWELL_CYC(24'd4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic       mr;
    logic       sb;
    logic       sel;
    logic [9:0] pos;
    logic       hold;
    logic       act;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic sel,
                       input logic [9:0] pos,
                       input logic hold,
                       input logic act,
                       input logic done);
    checks++;
    if ({bus.sel_test, bus.servo_test, bus.sort_hold,
         bus.maint_active, bus.sweep_done} !==
        {sel, pos, hold, act, done}) begin
      errors++;
      $display("FAIL %s: got sel=%0b pos=%0d hold=%0b act=%0b done=%0b need sel=%0b pos=%0d hold=%0b act=%0b done=%0b",
               name, bus.sel_test, bus.servo_test, bus.sort_hold,
               bus.maint_active, bus.sweep_done,
               sel, pos, hold, act, done);
    end
  endtask

  task automatic do_reset();
    bus.maint_req = 1'b0;
    bus.sort_busy = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [9:0] seq [10];
    seq = '{10'd0, 10'd300, 10'd600, 10'd900, 10'd1000,
            10'd700, 10'd400, 10'd100, 10'd0, 10'd300};

    tbl.push_back('{1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++)
        tbl.push_back('{1'b1, 1'b0, 1'b1, seq[k], 1'b1, 1'b1,
                        (k == 8 && j == 0)});

    do_reset();
    check("reset_state", 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_hold", 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.maint_req = tbl[i].mr;
      bus.sort_busy = tbl[i].sb;
      tick();
      check($sformatf("sweep_vec%0d", i), tbl[i].sel, tbl[i].pos,
            tbl[i].hold, tbl[i].act, tbl[i].done);
    end

    tick();
    check("pre_reset_600", 1'b1, 10'd600, 1'b1, 1'b1, 1'b0);
    #3 reset_n = 1'b0;
    #1 check("async_reset", 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    do_reset();

    bus.maint_req = 1'b1;
    bus.sort_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("drain_busy%0d", i),
            1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    end
    bus.sort_busy = 1'b0;
    tick();
    check("drain_exit", 1'b1, 10'd0, 1'b1, 1'b1, 1'b0);
    do_reset();

    bus.maint_req = 1'b1;
    bus.sort_busy = 1'b1;
    tick();
    check("abort_drain", 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    bus.maint_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_idle%0d", i),
            1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    end
    do_reset();

    bus.maint_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("rel_enter600", 1'b1, 10'd600, 1'b1, 1'b1, 1'b0);
    tick();
    check("rel_dwell2", 1'b1, 10'd600, 1'b1, 1'b1, 1'b0);
    bus.maint_req = 1'b0;
    tick();
    check("rel_hold3", 1'b1, 10'd600, 1'b1, 1'b1, 1'b0);
    tick();
    check("rel_hold4", 1'b1, 10'd600, 1'b1, 1'b1, 1'b0);
    tick();
    check("rel_release", 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("rel_idle", 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rel_idle2", 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
